// File: rtl/pong_pkg.sv
// pong_pkg -- definitions shared by the Pong datapath blocks.
//   state_t  : match controller phases (IDLE, SERVE, PLAY, GOAL, OVER)
//   WIN_*    : winner encodings driven on score_keeper.winner
//   SCREEN_W / SCREEN_H : playfield size in pixels
//   COORD_W  : width of the ball / paddle coordinate buses
package pong_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        GOAL  = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/serve_timer.sv
// serve_timer -- loadable down-counter that times the SERVE phase.
//   game_clk   in   game tick clock
//   rst        in   synchronous active-high reset (count -> 0)
//   load       in   load load_value on the next edge (has priority over en)
//   en         in   decrement on the next edge
//   load_value in   CNT_W  value to load
//   zero       out  high while the count register reads 0
module serve_timer #(
    parameter int CNT_W = 8
) (
    input  logic             game_clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge game_clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/score_keeper.sv
// score_keeper -- Pong match controller.
// Watches the ball X position for goals, keeps both scores, holds the ball
// block in reset between points and sequences IDLE/SERVE/PLAY/GOAL/OVER.
//
// Ports:
//   game_clk   in   game tick clock
//   rst        in   synchronous active-high reset
//   ball_x     in   10  ball X position (pixels)
//   ball_y     in   10  ball Y position (not used by the match logic)
//   start      in   start/serve button (level; rising edge detected here)
//   ball_rst   out  reset to the ball block, high outside PLAY
//   score_p1   out  4   player 1 score
//   score_p2   out  4   player 2 score
//   serve_dir  out  0 = serve toward player 1 (left), 1 = toward player 2
//   game_over  out  high in OVER
//   winner     out  2   WIN_NONE / WIN_P1 / WIN_P2
//
// Build option: SCORE_KEEPER_AUTO_SERVE_EN
//   defined     : SERVE ends after SERVE_DELAY cycles (serve_timer instantiated)
//   not defined : SERVE ends on a start rising edge; SERVE_DELAY is unused
import pong_pkg::*;

module score_keeper #(
    parameter int LEFT_GOAL_X  = 8,
    parameter int RIGHT_GOAL_X = 624,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_DELAY  = 60
) (
    input  logic               game_clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic               start,
    output logic               ball_rst,
    output logic [3:0]         score_p1,
    output logic [3:0]         score_p2,
    output logic               serve_dir,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam logic [3:0]         WIN_VAL = 4'(WIN_SCORE);
    localparam logic [COORD_W-1:0] LEFT_X  = COORD_W'(LEFT_GOAL_X);
    localparam logic [COORD_W-1:0] RIGHT_X = COORD_W'(RIGHT_GOAL_X);

    state_t state;
    logic   start_q;
    logic   start_rise;
    logic   goal_left;
    logic   goal_right;
    logic   serve_done;

    assign start_rise = start & ~start_q;
    assign goal_left  = (ball_x <= LEFT_X);
    assign goal_right = (ball_x >= RIGHT_X);

    // Y only matters for optional tracing; fold it away so it is not dangling.
    logic unused_ball_y;
    assign unused_ball_y = ^ball_y;

`ifdef SCORE_KEEPER_AUTO_SERVE_EN
    // Counter holds SERVE_DELAY-1 on SERVE entry; PLAY starts on the edge
    // that sees it at zero, giving exactly SERVE_DELAY SERVE cycles.
    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    logic timer_load;
    logic timer_en;
    logic timer_zero;

    assign timer_load = ((state == IDLE || state == OVER) && start_rise) ||
                        (state == GOAL && score_p1 != WIN_VAL && score_p2 != WIN_VAL);
    assign timer_en   = (state == SERVE);

    serve_timer #(
        .CNT_W (CNT_W)
    ) u_serve_timer (
        .game_clk   (game_clk),
        .rst        (rst),
        .load       (timer_load),
        .en         (timer_en),
        .load_value (CNT_W'(SERVE_DELAY - 1)),
        .zero       (timer_zero)
    );

    assign serve_done = timer_zero;
`else
    localparam int UNUSED_SERVE_DELAY = SERVE_DELAY;

    assign serve_done = start_rise;
`endif

    always_ff @(posedge game_clk) begin
        if (rst) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            serve_dir <= 1'b0;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start_rise) state <= SERVE;
                end
                SERVE: begin
                    if (serve_done) state <= PLAY;
                end
                PLAY: begin
                    // Left check first so overlapping goal zones resolve deterministically.
                    if (goal_left) begin
                        score_p2  <= score_p2 + 4'd1;
                        serve_dir <= 1'b0;
                        state     <= GOAL;
                    end else if (goal_right) begin
                        score_p1  <= score_p1 + 4'd1;
                        serve_dir <= 1'b1;
                        state     <= GOAL;
                    end
                end
                GOAL: begin
                    // Only the scorer's count can have just reached WIN_SCORE.
                    if (score_p1 == WIN_VAL) begin
                        winner    <= WIN_P1;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (score_p2 == WIN_VAL) begin
                        winner    <= WIN_P2;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        state <= SERVE;
                    end
                end
                OVER: begin
                    if (start_rise) begin
                        score_p1  <= 4'd0;
                        score_p2  <= 4'd0;
                        winner    <= WIN_NONE;
                        game_over <= 1'b0;
                        serve_dir <= 1'b0;
                        state     <= SERVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ball_rst = (state != PLAY);

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper -- directed bench for score_keeper (WIN_SCORE = 3,
// SERVE_DELAY = 4). Works with or without SCORE_KEEPER_AUTO_SERVE_EN.
`timescale 1ns/1ps
module tb_score_keeper;

    localparam int WIN_SCORE   = 3;
    localparam int SERVE_DELAY = 4;

    logic       game_clk = 1'b0;
    logic       rst;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       start;
    logic       ball_rst;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       serve_dir;
    logic       game_over;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    score_keeper #(
        .LEFT_GOAL_X  (8),
        .RIGHT_GOAL_X (624),
        .WIN_SCORE    (WIN_SCORE),
        .SERVE_DELAY  (SERVE_DELAY)
    ) dut (
        .game_clk  (game_clk),
        .rst       (rst),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .start     (start),
        .ball_rst  (ball_rst),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .serve_dir (serve_dir),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 game_clk = ~game_clk;

    // Advance one edge; outputs are observed 1 ns after it.
    task automatic tick();
        @(posedge game_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic br, input logic [3:0] p1,
                             input logic [3:0] p2, input logic dir, input logic go,
                             input logic [1:0] win);
        chk({tag, ".ball_rst"},  32'(ball_rst),  32'(br));
        chk({tag, ".score_p1"},  32'(score_p1),  32'(p1));
        chk({tag, ".score_p2"},  32'(score_p2),  32'(p2));
        chk({tag, ".serve_dir"}, 32'(serve_dir), 32'(dir));
        chk({tag, ".game_over"}, 32'(game_over), 32'(go));
        chk({tag, ".winner"},    32'(winner),    32'(win));
    endtask

    // One-cycle start pulse; after it the DUT is in SERVE.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the SERVE entry edge; leaves the DUT in PLAY.
    task automatic finish_serve(input string tag);
`ifdef SCORE_KEEPER_AUTO_SERVE_EN
        for (int i = 1; i < SERVE_DELAY; i++) begin
            tick();
            chk({tag, ".serve_hold"}, 32'(ball_rst), 32'd1);
        end
        tick();
        chk({tag, ".serve_end"}, 32'(ball_rst), 32'd0);
`else
        tick();
        chk({tag, ".serve_hold"}, 32'(ball_rst), 32'd1);
        pulse_start();
        chk({tag, ".serve_end"}, 32'(ball_rst), 32'd0);
`endif
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        ball_x = 10'd320;
        ball_y = 10'd240;

        // Reset and idle
        tick();
        tick();
        rst = 1'b0;
        chk_state("reset", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 100; i++) tick();
        chk_state("idle100", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);

        // Serve, then player 1 point at the right boundary
        pulse_start();
        chk("serve_entry.ball_rst", 32'(ball_rst), 32'd1);
        finish_serve("serve1");
        ball_x = 10'd624;
        tick();
        chk_state("p1_goal", 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00);
        ball_x = 10'd320;
        tick();
        chk_state("p1_after_goal", 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00);
        finish_serve("serve2");

        // Player 2 boundary: 9 is not a goal, 8 is
        ball_x = 10'd9;
        tick();
        chk_state("x9_no_goal", 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00);
        ball_x = 10'd8;
        tick();
        chk_state("x8_goal", 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 2'b00);
        ball_x = 10'd320;
        tick();
        finish_serve("serve3");

        // Two more player 2 goals end the match
        ball_x = 10'd0;
        tick();
        chk("p2_second.score_p2", 32'(score_p2), 32'd2);
        ball_x = 10'd320;
        tick();
        finish_serve("serve4");
        ball_x = 10'd0;
        tick();
        chk_state("p2_third", 1'b1, 4'd1, 4'd3, 1'b0, 1'b0, 2'b00);
        tick();
        chk_state("match_over", 1'b1, 4'd1, 4'd3, 1'b0, 1'b1, 2'b10);
        for (int i = 0; i < 3; i++) tick();
        chk_state("over_ignores_ball", 1'b1, 4'd1, 4'd3, 1'b0, 1'b1, 2'b10);

        // Restart from OVER
        ball_x = 10'd320;
        pulse_start();
        chk_state("restart", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);

        // Reset during SERVE countdown
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("rst_in_serve", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 6; i++) tick();
        chk("rst_serve_stays_idle.ball_rst", 32'(ball_rst), 32'd1);

        // Reset during GOAL
        pulse_start();
        finish_serve("serve5");
        ball_x = 10'd630;
        tick();
        chk("goal_before_rst.score_p1", 32'(score_p1), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("rst_in_goal", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) tick();
        chk_state("idle_ignores_ball", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);

        // A held start yields a single edge: SERVE entered, no early PLAY
        ball_x = 10'd320;
        start  = 1'b1;
        tick();
        for (int i = 0; i < SERVE_DELAY - 1; i++) tick();
        chk("held_start.ball_rst", 32'(ball_rst), 32'd1);
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
